// File: rtl/pipe_nco_pkg.sv
// Shared constants and helpers for the NCO phase accumulator and the CORDIC pipe it feeds.
package pipe_nco_pkg;

    localparam int DEF_PHASE_W = 32;
    localparam int DEF_SEG_W   = 8;

    // Per-step controls carried alongside the skewed data words.
    typedef struct packed {
        logic en;
        logic load;
    } step_ctl_t;

    // Input-to-output latency: one input register plus one register per segment.
    function automatic int pipe_lat(input int phase_w, input int seg_w);
        return phase_w / seg_w + 1;
    endfunction

endpackage

// File: rtl/pipe_phase_acc_if.sv
// Step request / phase output bundle between the NCO controller and the phase accumulator.
interface pipe_phase_acc_if
    import pipe_nco_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W
);

    logic               en;
    logic               sync_load;
    logic [PHASE_W-1:0] fcw;
    logic [PHASE_W-1:0] init_phase;
    logic [PHASE_W-1:0] phase;
    logic               out_valid;
    logic               wrap;

    modport master (
        output en, sync_load, fcw, init_phase,
        input  phase, out_valid, wrap
    );

    modport slave (
        input  en, sync_load, fcw, init_phase,
        output phase, out_valid, wrap
    );

endinterface

// File: rtl/pa_seg.sv
// One SEG_W-bit slice of the carry-pipelined phase accumulator with registered sum and carry.
module pa_seg #(
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [SEG_W-1:0] load_val,
    input  logic [SEG_W-1:0] fcw,
    input  logic             carry_in,
    output logic [SEG_W-1:0] sum,
    output logic             carry_out
);

    logic [SEG_W:0] add_full;

    assign add_full = {1'b0, sum} + {1'b0, fcw} + {{SEG_W{1'b0}}, carry_in};

    // A load drops any carry arriving from below; a stall holds the slice and emits no carry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (load) begin
            sum       <= load_val;
            carry_out <= 1'b0;
        end else if (en) begin
            {carry_out, sum} <= add_full;
        end else begin
            carry_out <= 1'b0;
        end
    end

endmodule

// File: rtl/skew_dly.sv
// Fixed-depth register delay line used for input skew and output de-skew; DEPTH=0 is a wire.
module skew_dly #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset;
        assign q = d;
    end else begin : g_reg
        logic [WIDTH-1:0] stages [DEPTH];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stages[i] <= '0;
                end
            end else begin
                stages[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    stages[i] <= stages[i-1];
                end
            end
        end

        assign q = stages[DEPTH-1];
    end

endmodule

// File: rtl/pipe_phase_acc.sv
// Carry-pipelined phase accumulator: skewed segment adders, de-skewed coherent output, aligned valid/wrap.
module pipe_phase_acc
    import pipe_nco_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int SEG_W   = DEF_SEG_W
) (
    input  logic            clk,
    input  logic            reset,
    pipe_phase_acc_if.slave bus
);

    localparam int NSEG  = PHASE_W / SEG_W;
    localparam int LAT   = pipe_lat(PHASE_W, SEG_W);
    localparam int CTL_W = 2 * SEG_W + 2;

    step_ctl_t          s0_ctl;
    logic [PHASE_W-1:0] s0_fcw;
    logic [PHASE_W-1:0] s0_init;
    logic [PHASE_W-1:0] phase_aligned;
    logic [NSEG:0]      carry;
    logic               step_valid;
    logic               wrap_hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0_ctl  <= '0;
            s0_fcw  <= '0;
            s0_init <= '0;
        end else begin
            s0_ctl.en   <= bus.en;
            s0_ctl.load <= bus.sync_load;
            s0_fcw      <= bus.fcw;
            s0_init     <= bus.init_phase;
        end
    end

    assign carry[0] = 1'b0;

    // Segment k runs k cycles behind segment 0 so it meets the carry of the same step.
    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        logic [CTL_W-1:0] ctl_in;
        logic [CTL_W-1:0] ctl_dly;
        step_ctl_t        seg_ctl;
        logic [SEG_W-1:0] seg_fcw;
        logic [SEG_W-1:0] seg_init;
        logic [SEG_W-1:0] sum_raw;

        assign ctl_in = {s0_ctl, s0_fcw[k*SEG_W +: SEG_W], s0_init[k*SEG_W +: SEG_W]};

        skew_dly #(
            .WIDTH (CTL_W),
            .DEPTH (k)
        ) u_skew (
            .clk   (clk),
            .reset (reset),
            .d     (ctl_in),
            .q     (ctl_dly)
        );

        assign {seg_ctl, seg_fcw, seg_init} = ctl_dly;

        pa_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .clk       (clk),
            .reset     (reset),
            .en        (seg_ctl.en),
            .load      (seg_ctl.load),
            .load_val  (seg_init),
            .fcw       (seg_fcw),
            .carry_in  (carry[k]),
            .sum       (sum_raw),
            .carry_out (carry[k+1])
        );

        skew_dly #(
            .WIDTH (SEG_W),
            .DEPTH (NSEG - 1 - k)
        ) u_deskew (
            .clk   (clk),
            .reset (reset),
            .d     (sum_raw),
            .q     (phase_aligned[k*SEG_W +: SEG_W])
        );
    end

    skew_dly #(
        .WIDTH (1),
        .DEPTH (LAT - 1)
    ) u_valid_dly (
        .clk   (clk),
        .reset (reset),
        .d     (s0_ctl.en | s0_ctl.load),
        .q     (step_valid)
    );

    // The top carry register clears on idle cycles, so the last wrap is kept separately for bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_hold <= 1'b0;
        end else if (step_valid) begin
            wrap_hold <= carry[NSEG];
        end
    end

    assign bus.phase     = phase_aligned;
    assign bus.out_valid = step_valid;
    assign bus.wrap      = step_valid ? carry[NSEG] : wrap_hold;

endmodule

// File: tb/tb_pipe_phase_acc.sv
// Checks a 16/4 and an 8/8 phase accumulator against an arithmetic step model, in lockstep.
module tb_pipe_phase_acc;

    localparam int W_A   = 16;
    localparam int SEG_A = 4;
    localparam int LAT_A = 5;
    localparam int W_B   = 8;
    localparam int SEG_B = 8;
    localparam int LAT_B = 2;

    typedef struct packed {
        logic        valid;
        logic        wrap;
        logic [15:0] phase;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        last_a = '0;
    exp_t        last_b = '0;
    logic [16:0] obs_a[$];
    logic [16:0] obs_b[$];

    pipe_phase_acc_if #(.PHASE_W(W_A)) bus_a();
    pipe_phase_acc_if #(.PHASE_W(W_B)) bus_b();

    pipe_phase_acc #(.PHASE_W(W_A), .SEG_W(SEG_A)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    pipe_phase_acc #(.PHASE_W(W_B), .SEG_W(SEG_B)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One architectural step: load wins over accumulate; idle steps keep the last phase and wrap.
    function automatic exp_t modelStep(input int width, input exp_t last, input logic en,
                                       input logic ld, input logic [15:0] f, input logic [15:0] ip);
        longint m;
        longint s;
        exp_t   r;
        m = longint'(1) << width;
        r = last;
        r.valid = 1'b0;
        if (ld) begin
            r.valid = 1'b1;
            r.wrap  = 1'b0;
            r.phase = 16'(longint'(ip) % m);
        end else if (en) begin
            s = longint'(last.phase) + (longint'(f) % m);
            r.valid = 1'b1;
            r.wrap  = (s >= m);
            r.phase = 16'(s % m);
        end
        return r;
    endfunction

    task automatic compareCycle();
        exp_t ea;
        exp_t eb;
        ea = '0;
        eb = '0;
        if (qa.size() >= LAT_A) ea = qa.pop_front();
        if (qb.size() >= LAT_B) eb = qb.pop_front();
        checkOutput("a_valid", 32'(bus_a.out_valid), 32'(ea.valid));
        checkOutput("a_phase", 32'(bus_a.phase), 32'(ea.phase));
        checkOutput("a_wrap", 32'(bus_a.wrap), 32'(ea.wrap));
        checkOutput("b_valid", 32'(bus_b.out_valid), 32'(eb.valid));
        checkOutput("b_phase", 32'(bus_b.phase), 32'(eb.phase));
        checkOutput("b_wrap", 32'(bus_b.wrap), 32'(eb.wrap));
        if (bus_a.out_valid) obs_a.push_back({bus_a.wrap, bus_a.phase});
        if (bus_b.out_valid) obs_b.push_back({bus_b.wrap, 8'h00, bus_b.phase});
    endtask

    task automatic applyStimulus(input logic en, input logic ld, input logic [15:0] f, input logic [15:0] ip);
        @(negedge clk);
        compareCycle();
        bus_a.en         = en;
        bus_a.sync_load  = ld;
        bus_a.fcw        = f;
        bus_a.init_phase = ip;
        bus_b.en         = en;
        bus_b.sync_load  = ld;
        bus_b.fcw        = f[7:0];
        bus_b.init_phase = ip[7:0];
        last_a = modelStep(W_A, last_a, en, ld, f, ip);
        qa.push_back(last_a);
        last_b = modelStep(W_B, last_b, en, ld, f, ip);
        qb.push_back(last_b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 16'($urandom), 16'($urandom));
        end
    endtask

    task automatic checkObs(input string tag, input bit use_b, input int idx, input logic [16:0] exp);
        int          n;
        logic [16:0] got;
        n = use_b ? obs_b.size() : obs_a.size();
        if (idx >= n) begin
            checkOutput({tag, "_present"}, 32'(n), 32'(idx + 1));
        end else begin
            got = use_b ? obs_b[idx] : obs_a[idx];
            checkOutput(tag, 32'(got), 32'(exp));
        end
    endtask

    task automatic randomStep();
        logic        en;
        logic        ld;
        logic [15:0] f;
        en = ($urandom_range(0, 3) != 0);
        ld = ($urandom_range(0, 11) == 0);
        f  = 16'($urandom);
        if ($urandom_range(0, 3) == 0) f = 16'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) f = 16'hFFFF - 16'($urandom_range(0, 3));
        applyStimulus(en, ld, f, 16'($urandom));
    endtask

    task automatic resetPulse();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_a_valid", 32'(bus_a.out_valid), 32'd0);
        checkOutput("rst_a_phase", 32'(bus_a.phase), 32'd0);
        checkOutput("rst_a_wrap", 32'(bus_a.wrap), 32'd0);
        checkOutput("rst_b_valid", 32'(bus_b.out_valid), 32'd0);
        checkOutput("rst_b_phase", 32'(bus_b.phase), 32'd0);
        qa.delete();
        qb.delete();
        last_a = '0;
        last_b = '0;
        bus_a.en = 1'b0;
        bus_a.sync_load = 1'b0;
        bus_b.en = 1'b0;
        bus_b.sync_load = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bus_a.en = 1'b0;  bus_a.sync_load = 1'b0;  bus_a.fcw = '0;  bus_a.init_phase = '0;
        bus_b.en = 1'b0;  bus_b.sync_load = 1'b0;  bus_b.fcw = '0;  bus_b.init_phase = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_a_valid", 32'(bus_a.out_valid), 32'd0);
        checkOutput("reset_a_phase", 32'(bus_a.phase), 32'd0);
        checkOutput("reset_b_valid", 32'(bus_b.out_valid), 32'd0);
        reset = 1'b1;

        // Counting by one from zero: exercises every inter-segment carry edge.
        obs_a.delete(); obs_b.delete();
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0000);
        idle(LAT_A + 1);
        checkOutput("s1_count_a", 32'(obs_a.size()), 32'd21);
        checkOutput("s1_count_b", 32'(obs_b.size()), 32'd21);
        for (int i = 0; i <= 20; i++) checkObs("s1_seq_a", 1'b0, i, 17'(i));
        checkObs("s1_seq_b", 1'b1, 16, 17'h00010);

        // Wrap across the top of the phase range.
        obs_a.delete(); obs_b.delete();
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'hFFF0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'h0008, 16'h0000);
        idle(LAT_A + 1);
        checkObs("s2_load", 1'b0, 0, 17'h0FFF0);
        checkObs("s2_fff8", 1'b0, 1, 17'h0FFF8);
        checkObs("s2_wrap", 1'b0, 2, 17'h10000);
        checkObs("s2_after", 1'b0, 3, 17'h00008);
        checkObs("s2_b_wrap", 1'b1, 2, 17'h10000);

        // FCW change mid-stream must not mix words.
        obs_a.delete(); obs_b.delete();
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'h0FFF, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0000);
        idle(LAT_A + 1);
        checkObs("s3_0", 1'b0, 1, 17'h00FFF);
        checkObs("s3_1", 1'b0, 2, 17'h01FFE);
        checkObs("s3_2", 1'b0, 3, 17'h02FFD);
        checkObs("s3_3", 1'b0, 4, 17'h02FFE);

        // Stall gaps become bubbles.
        obs_a.delete(); obs_b.delete();
        applyStimulus(1'b0, 1'b1, 16'h0111, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0111, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0111, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0111, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0111, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0111, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0111, 16'h0000);
        idle(LAT_A + 1);
        checkOutput("s4_count", 32'(obs_a.size()), 32'd4);
        checkObs("s4_0", 1'b0, 1, 17'h00111);
        checkObs("s4_1", 1'b0, 2, 17'h00222);
        checkObs("s4_2", 1'b0, 3, 17'h00333);

        // Load and enable together: load wins.
        obs_a.delete(); obs_b.delete();
        applyStimulus(1'b1, 1'b1, 16'h1234, 16'hABCD);
        applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0000);
        idle(LAT_A + 1);
        checkObs("s5_load", 1'b0, 0, 17'h0ABCD);
        checkObs("s5_next", 1'b0, 1, 17'h0ABCE);

        // Random traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 250; i++) randomStep();
        resetPulse();
        for (int i = 0; i < 250; i++) randomStep();
        idle(LAT_A + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pipe_phase_acc.md
Name: pipe_phase_acc

Overview:
- Parametrised, carry-pipelined phase accumulator (NCO front end) feeding the pipelined CORDIC.
- PHASE_W-bit accumulator split into NSEG segments of SEG_W bits. The carry between segments is registered, the input is skewed per segment, and the output is de-skewed, so the output phase word is coherent.
- Adds features the earlier fixed 16-bit accumulator lacks:
  - clock-enable stalling
  - coherent synchronous phase load
  - coherent mid-stream FCW change
  - aligned output-valid and wrap flag

Parameters:
- PHASE_W, 32, accumulator/phase width in bits; must be a multiple of SEG_W.
- SEG_W, 8, bits per pipelined adder segment; 1 <= SEG_W <= PHASE_W.
- NSEG, PHASE_W/SEG_W, derived localparam; number of segments.
- LAT, NSEG+1, derived localparam; input-to-output latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  accumulate step request; sampled every cycle.
- fcw  in  PHASE_W  frequency control word; sampled in the cycles en=1.
- sync_load  in  1  load accumulator with init_phase this step; has priority over en.
- init_phase  in  PHASE_W  load value, sampled when sync_load=1.
- phase  out  PHASE_W  aligned accumulator value.
- out_valid  out  1  phase/wrap correspond to a step taken LAT cycles earlier.
- wrap  out  1  step overflowed modulo 2^PHASE_W (carry out of the top segment); aligned with phase.

Behaviour:
- Reset (reset=0, asynchronous): every register clears to 0, including accumulators, skew/de-skew lines and carry registers. Outputs: phase=0, out_valid=0, wrap=0.
- Architectural model, step at input cycle c, evaluated in this priority order:
  - If sync_load=1: A <= init_phase; wrap=0; valid step.
  - Else if en=1: {wrap, A} <= A + fcw, modulo 2^PHASE_W; valid step.
  - Else: no step. A holds, and no valid output is produced for cycle c.
- Output timing: at cycle c+LAT, out_valid=1 and phase equals the post-step A for every valid step.
  - In non-step cycles out_valid=0, and phase/wrap hold their last valid values.
- Pipeline structure:
  - Stage 0: input register capturing fcw, init_phase, en and sync_load.
  - Segment k (bit slice k*SEG_W +: SEG_W, k=0 is LSB) sees the stage-0 controls and data delayed by k further cycles.
  - Segment k adds its carry-in (registered carry-out of segment k-1 from the previous cycle; 0 for k=0) only when its delayed en=1 and sync_load=0.
  - Registered carry-out clears when the segment does not add.
  - Segment k result passes through NSEG-1-k de-skew registers, so all slices arrive together at LAT.
- Stalls: a skewed en gates each segment and its carry register, so a stall cycle propagates as a bubble. Arbitrary en patterns, including single-cycle gaps and long idles, give results identical to the model.
- FCW change: any new fcw is used exactly from the step it is sampled in; no partial-word mixing.
- sync_load: discards any in-flight carry for that step at every segment.
- Simultaneous sync_load and en: sync_load wins; fcw is ignored that step.
- Wrap detection: wrap is the carry out of segment NSEG-1 for that step, delayed 0 cycles (top segment has no de-skew).
- Reset mid-operation: all in-flight steps are discarded. After reset release, the first valid output appears LAT cycles after the first step.
- NSEG=1: single segment, LAT=2, no skew/de-skew registers generated.
- Throughput: one step per cycle, sustained.

Decomposition:
- Shared package (pipe_nco_pkg) holds localparam helpers used by the CORDIC pipe: default PHASE_W/SEG_W and the latency formula function.
- Natural sub-module: pa_seg. It is one SEG_W-bit accumulator slice with:
  - inputs: en, load, load value, fcw slice, carry_in
  - outputs: registered sum, registered carry_out
  - asynchronous active-low reset
- Generic delay line: skew_dly (parameter WIDTH, DEPTH; DEPTH=0 means a wire). It is instantiated for input skew and output de-skew.

Test Plan (PHASE_W=16, SEG_W=4, LAT=5 unless noted):
1. Reset release, sync_load init_phase=0x0000, then en=1 with fcw=0x0001 for 20 cycles -> out_valid rises 5 cycles after the load. Outputs are 0x0000, 0x0001, ... Output 0x000F->0x0010 is correct, proving carry ripple.
2. Load 0xFFF0, fcw=0x0008, continuous en -> outputs 0xFFF8, 0x0000 with wrap=1 on 0x0000 only, then 0x0008 with wrap=0.
3. fcw=0x0FFF for 3 steps, then 0x0001 -> outputs 0x0FFF, 0x1FFE, 0x2FFD, 0x2FFE. No mixed-word glitch.
4. Pattern en=1,0,0,1,0,1 with fcw=0x0111 from load 0 -> three valid outputs 0x0111, 0x0222, 0x0333. out_valid low in gap cycles, phase held.
5. sync_load=1 with en=1, fcw=0x1234, init_phase=0xABCD in the same cycle -> output 0xABCD, wrap=0. Next step with fcw=0x0001 gives 0xABCE.
6. reset asserted mid-stream for 1 cycle -> phase=0 and out_valid=0 immediately. Repeat scenario 1 with PHASE_W=8, SEG_W=8 (LAT=2): outputs match the model.
